// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the loader byte stream, core fetch PC and instruction-memory port.
// The slave side is the loader/arbiter; the master side is the surrounding system.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              i_load_start;
    logic [15:0]       i_load_len;
    logic [7:0]        i_byte;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic [ADDR_W-1:0] i_pc;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              o_mem_we;
    logic              o_cpu_stall;
    logic              o_load_done;
    logic              o_load_err;

    modport master (
        output i_load_start, i_load_len, i_byte, i_byte_valid, i_pc,
        input  o_byte_ready, o_mem_addr, o_mem_wdata, o_mem_we,
               o_cpu_stall, o_load_done, o_load_err
    );

    modport slave (
        input  i_load_start, i_load_len, i_byte, i_byte_valid, i_pc,
        output o_byte_ready, o_mem_addr, o_mem_wdata, o_mem_we,
               o_cpu_stall, o_load_done, o_load_err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into little-endian words, writes them to instruction memory
// while stalling the core. Define IMEM_LOAD_CKSUM_EN to require a trailing 8-bit checksum byte.
module imem_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    imem_loader_if.slave bus
);

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        CHECK,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [15:0]       len_q;
    logic [15:0]       word_cnt;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic [ADDR_W-1:0] wr_addr;
    logic              rej_err_q;

`ifdef IMEM_LOAD_CKSUM_EN
    logic [7:0]        sum_q;
    logic              cksum_bad_q;
`endif

    logic              byte_ready;
    logic              cpu_stall;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              load_done;
    logic              load_err;
    logic              accept;
    logic              len_ok;
    logic              last_word;

    assign accept    = bus.i_byte_valid & byte_ready;
    assign len_ok    = (bus.i_load_len != 16'd0) && ({16'd0, bus.i_load_len} <= MAX_WORDS_W);
    assign last_word = (word_cnt == (len_q - 16'd1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_load_start && len_ok) state_next = COLLECT;
            COLLECT: if (accept && (byte_cnt == 2'd3)) state_next = WRITE;
`ifdef IMEM_LOAD_CKSUM_EN
            WRITE:   state_next = last_word ? CHECK : COLLECT;
            CHECK:   if (accept) state_next = DONE;
`else
            WRITE:   state_next = last_word ? DONE : COLLECT;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A rejected request reports its error from IDLE on the following cycle.
    always_comb begin
        byte_ready = 1'b0;
        cpu_stall  = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 32'd0;
        load_done  = 1'b0;
        load_err   = rej_err_q;
        case (state)
            COLLECT: begin
                cpu_stall  = 1'b1;
                byte_ready = 1'b1;
            end
            WRITE: begin
                cpu_stall = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = word_buf;
            end
`ifdef IMEM_LOAD_CKSUM_EN
            CHECK: begin
                cpu_stall  = 1'b1;
                byte_ready = 1'b1;
            end
            DONE: begin
                cpu_stall = 1'b1;
                load_done = 1'b1;
                load_err  = rej_err_q | cksum_bad_q;
            end
`else
            DONE: begin
                cpu_stall = 1'b1;
                load_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q       <= 16'd0;
            word_cnt    <= 16'd0;
            byte_cnt    <= 2'd0;
            word_buf    <= 32'd0;
            wr_addr     <= BASE_ADDR;
            rej_err_q   <= 1'b0;
`ifdef IMEM_LOAD_CKSUM_EN
            sum_q       <= 8'd0;
            cksum_bad_q <= 1'b0;
`endif
        end else begin
            rej_err_q <= (state == IDLE) && bus.i_load_start && !len_ok;
            if ((state == IDLE) && bus.i_load_start && len_ok) begin
                len_q       <= bus.i_load_len;
                wr_addr     <= BASE_ADDR;
                byte_cnt    <= 2'd0;
                word_cnt    <= 16'd0;
`ifdef IMEM_LOAD_CKSUM_EN
                sum_q       <= 8'd0;
                cksum_bad_q <= 1'b0;
`endif
            end
            if ((state == COLLECT) && accept) begin
                word_buf[{byte_cnt, 3'b000} +: 8] <= bus.i_byte;
                byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOAD_CKSUM_EN
                sum_q    <= sum_q + bus.i_byte;
`endif
            end
            if (state == WRITE) begin
                wr_addr  <= wr_addr + ADDR_W'(4);
                word_cnt <= word_cnt + 16'd1;
            end
`ifdef IMEM_LOAD_CKSUM_EN
            if ((state == CHECK) && accept) begin
                cksum_bad_q <= (bus.i_byte != sum_q);
            end
`endif
        end
    end

    assign bus.o_byte_ready = byte_ready;
    assign bus.o_cpu_stall  = cpu_stall;
    assign bus.o_mem_we     = mem_we;
    assign bus.o_mem_wdata  = mem_wdata;
    assign bus.o_load_done  = load_done;
    assign bus.o_load_err   = load_err;
    assign bus.o_mem_addr   = cpu_stall ? wr_addr : bus.i_pc;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads against a word-level reference model; a negedge monitor
// pops expected writes, done and error events from a scoreboard queue.
module tb_imem_loader;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam int          MAX_W  = 6;

    typedef enum int {EV_WRITE, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } ev_t;

    ev_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic expect_idle_next = 1'b0;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAX_W)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: DUT event with no matching expectation (queue size %0d) at %0t",
                 name, sb.size(), $time);
    endtask

    // Monitor: every DUT write/done/error must match the head of the scoreboard.
    always @(negedge clk) begin
        ev_t ev;
        if (rst_n) begin
            if (expect_idle_next) begin
                check_output("stall_after_done", 32'(bus.o_cpu_stall), 32'd0);
                expect_idle_next = 1'b0;
            end
            if (!bus.o_cpu_stall)
                check_output("addr_mux_pc", bus.o_mem_addr, bus.i_pc);
            if (bus.o_mem_we) begin
                if (sb.size() == 0 || sb[0].kind != EV_WRITE) begin
                    report_unexpected("unexpected_we");
                end else begin
                    ev = sb.pop_front();
                    check_output("write_addr", bus.o_mem_addr, ev.addr);
                    check_output("write_data", bus.o_mem_wdata, ev.data);
                    check_output("write_stall", 32'(bus.o_cpu_stall), 32'd1);
                end
            end
            if (bus.o_load_done) begin
                if (sb.size() == 0 || sb[0].kind != EV_DONE) begin
                    report_unexpected("unexpected_done");
                end else begin
                    ev = sb.pop_front();
                    check_output("done_err", 32'(bus.o_load_err), 32'(ev.err));
                    expect_idle_next = 1'b1;
                end
            end else if (bus.o_load_err) begin
                if (sb.size() == 0 || sb[0].kind != EV_ERR) begin
                    report_unexpected("unexpected_err");
                end else begin
                    ev = sb.pop_front();
                    check_output("reject_err_stall", 32'(bus.o_cpu_stall), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_pc = $urandom;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   budget;
        bus.i_byte_valid = 1'b0;
        repeat (gap) tick();
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 40) begin
            @(negedge clk);
            acc = bus.o_byte_ready;
            tick();
            budget++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL byte_accept_timeout: byte 0x%02h not accepted, required within 40 cycles", b);
        end
        bus.i_byte_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((sb.size() != 0 || expect_idle_next) && budget < 40) begin
            tick();
            budget++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d expected events outstanding, required 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    // Reference model: word w is bytes 4w..4w+3 little-endian at BASE+4w; checksum is the byte sum mod 256.
    task automatic apply_stimulus(input int len, input logic [7:0] data[$], input int max_gap,
                                  input bit mid_start, input int cks_sel);
        ev_t        ev;
        logic [7:0] sum;
        logic [7:0] cks;
        sum = 8'd0;
        for (int w = 0; w < len; w++) begin
            ev.kind = EV_WRITE;
            ev.addr = BASE + 32'(4 * w);
            ev.data = {data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]};
            ev.err  = 1'b0;
            sb.push_back(ev);
        end
        foreach (data[i]) sum = sum + data[i];
        cks = (cks_sel == 0) ? sum : ((cks_sel == 1) ? 8'h00 : ~sum);
        ev.kind = EV_DONE;
        ev.addr = 32'd0;
        ev.data = 32'd0;
`ifdef IMEM_LOAD_CKSUM_EN
        ev.err  = (cks != sum);
`else
        ev.err  = 1'b0;
`endif
        sb.push_back(ev);

        bus.i_load_start = 1'b1;
        bus.i_load_len   = 16'(len);
        tick();
        bus.i_load_start = 1'b0;
        foreach (data[i]) begin
            send_byte(data[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
            if (mid_start && i == 1) begin
                bus.i_load_start = 1'b1;
                bus.i_load_len   = 16'd2;
                tick();
                bus.i_load_start = 1'b0;
            end
        end
`ifdef IMEM_LOAD_CKSUM_EN
        send_byte(cks, 0);
`endif
        wait_drain();
    endtask

    task automatic reject_request(input logic [15:0] len);
        ev_t ev;
        ev.kind = EV_ERR;
        ev.addr = 32'd0;
        ev.data = 32'd0;
        ev.err  = 1'b1;
        sb.push_back(ev);
        bus.i_load_start = 1'b1;
        bus.i_load_len   = len;
        tick();
        bus.i_load_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("reject_stall", 32'(bus.o_cpu_stall), 32'd0);
            tick();
        end
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] fixed8[$];
        logic [7:0] fixed4[$];
        logic [7:0] rnd[$];
        int         len;

        bus.i_load_start = 1'b0;
        bus.i_load_len   = 16'd0;
        bus.i_byte       = 8'd0;
        bus.i_byte_valid = 1'b0;
        bus.i_pc         = 32'h40;
        rst_n            = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_ready", 32'(bus.o_byte_ready), 32'd0);
        check_output("rst_we",    32'(bus.o_mem_we),     32'd0);
        check_output("rst_wdata", bus.o_mem_wdata,       32'd0);
        check_output("rst_stall", 32'(bus.o_cpu_stall),  32'd0);
        check_output("rst_done",  32'(bus.o_load_done),  32'd0);
        check_output("rst_err",   32'(bus.o_load_err),   32'd0);
        check_output("rst_addr",  bus.o_mem_addr,        32'h40);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            bus.i_pc = $urandom;
            #1;
            check_output("pc_track", bus.o_mem_addr, bus.i_pc);
            tick();
        end

        fixed8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        fixed4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        apply_stimulus(2, fixed8, 0, 1'b0, 0);
`ifdef IMEM_LOAD_CKSUM_EN
        apply_stimulus(2, fixed8, 0, 1'b0, 1);
`endif

        reject_request(16'd0);
        reject_request(16'(MAX_W + 1));
        reject_request(16'hFFFF);

        apply_stimulus(1, fixed4, 3, 1'b1, 0);

        // Reset in the middle of a word: nothing may be written and stall must drop at once.
        bus.i_load_start = 1'b1;
        bus.i_load_len   = 16'd1;
        tick();
        bus.i_load_start = 1'b0;
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("midrst_stall_now", 32'(bus.o_cpu_stall), 32'd0);
        @(negedge clk);
        check_output("midrst_we",    32'(bus.o_mem_we),    32'd0);
        check_output("midrst_stall", 32'(bus.o_cpu_stall), 32'd0);
        check_output("midrst_addr",  bus.o_mem_addr,       bus.i_pc);
        tick();
        rst_n = 1'b1;
        tick();
        apply_stimulus(1, fixed4, 2, 1'b0, 0);

        rnd.delete();
        for (int i = 0; i < 4 * MAX_W; i++) rnd.push_back(8'($urandom));
        apply_stimulus(MAX_W, rnd, 1, 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            len = int'($urandom_range(MAX_W, 1));
            rnd.delete();
            for (int i = 0; i < 4 * len; i++) rnd.push_back(8'($urandom));
            apply_stimulus(len, rnd, 3, 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)));
        end

        repeat (3) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: %0d events outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
